// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a shared single-port RAM: round-robin grants, optional
// locked bursts capped at MAX_BURST, and registered read-data return per requester.
module ram_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic          a_lock,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic [DW-1:0] a_rdata,
   output logic          a_rvalid,
   input  logic          b_req,
   input  logic          b_we,
   input  logic          b_lock,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic [DW-1:0] b_rdata,
   output logic          b_rvalid,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam int            CW      = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
   localparam logic          LAST_A  = 1'b0;
   localparam logic          LAST_B  = 1'b1;

   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

   state_t        r_state, w_state_next;
   logic          r_last, w_last_next;
   logic [CW-1:0] r_hold_cnt, w_hold_next, w_hold_inc;
   logic          w_gnt_a, w_gnt_b;

   // Owner keeps the RAM while requesting; otherwise fall back to round-robin on r_last.
   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      if (!rst) begin
         if (r_state == OWN_A && a_req) begin
            w_gnt_a = 1'b1;
         end else if (r_state == OWN_B && b_req) begin
            w_gnt_b = 1'b1;
         end else if (a_req && b_req) begin
            w_gnt_a = (r_last == LAST_B);
            w_gnt_b = (r_last == LAST_A);
         end else begin
            w_gnt_a = a_req;
            w_gnt_b = b_req;
         end
      end
   end

   always_comb begin
      w_state_next = IDLE;
      w_hold_next  = '0;
      w_last_next  = r_last;
      w_hold_inc   = '0;
      if (w_gnt_a) begin
         w_last_next = LAST_A;
         w_hold_inc  = (r_state == OWN_A) ? r_hold_cnt + CW'(1) : CW'(1);
         if (a_lock && w_hold_inc < MAX_CNT) begin
            w_state_next = OWN_A;
            w_hold_next  = w_hold_inc;
         end
      end else if (w_gnt_b) begin
         w_last_next = LAST_B;
         w_hold_inc  = (r_state == OWN_B) ? r_hold_cnt + CW'(1) : CW'(1);
         if (b_lock && w_hold_inc < MAX_CNT) begin
            w_state_next = OWN_B;
            w_hold_next  = w_hold_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_last     <= LAST_B;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_last     <= w_last_next;
         r_hold_cnt <= w_hold_next;
      end
   end

   assign a_gnt     = w_gnt_a;
   assign b_gnt     = w_gnt_b;
   assign ram_cs    = w_gnt_a | w_gnt_b;
   assign ram_we    = (w_gnt_a & a_we) | (w_gnt_b & b_we);
   assign ram_addr  = w_gnt_b ? b_addr  : a_addr;
   assign ram_wdata = w_gnt_b ? b_wdata : a_wdata;

   // Per-requester read return: index 0 is A, index 1 is B.
   logic [1:0]    w_rd_fire;
   logic [DW-1:0] r_rdata  [2];
   logic [1:0]    r_rvalid;

   assign w_rd_fire[0] = w_gnt_a & ~a_we;
   assign w_rd_fire[1] = w_gnt_b & ~b_we;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         always_ff @(posedge clk) begin
            if (rst) begin
               r_rdata[gi]  <= '0;
               r_rvalid[gi] <= 1'b0;
            end else begin
               r_rvalid[gi] <= w_rd_fire[gi];
               if (w_rd_fire[gi]) r_rdata[gi] <= ram_rdata;
            end
         end
      end
   endgenerate

   assign a_rdata  = r_rdata[0];
   assign a_rvalid = r_rvalid[0];
   assign b_rdata  = r_rdata[1];
   assign b_rvalid = r_rvalid[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with a behavioural 256x8 RAM
// (combinational read, write on negedge).
module tb_ram_arbiter;

   logic       clk;
   logic       rst;
   logic       a_req, a_we, a_lock, b_req, b_we, b_lock;
   logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
   logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [7:0] a_rdata, b_rdata;
   logic       ram_cs, ram_we;
   logic [7:0] ram_addr, ram_wdata, ram_rdata;

   logic [7:0] mem [256];

   ram_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: preset contents, then commit writes on the falling edge.
   assign ram_rdata = mem[ram_addr];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
      forever begin
         @(negedge clk);
         if (ram_cs && ram_we) mem[ram_addr] = ram_wdata;
      end
   end

   typedef struct {
      logic       rst;
      logic       ar, aw, al;
      logic [7:0] aa, ad;
      logic       br, bw, bl;
      logic [7:0] ba, bd;
      logic       eag, ebg;
      logic       earv;
      logic [7:0] eard;
      logic       ebrv;
      logic [7:0] ebrd;
   } vec_t;

   function automatic vec_t mk(
      input logic r,
      input logic ar, input logic aw, input logic al, input logic [7:0] aa, input logic [7:0] ad,
      input logic br, input logic bw, input logic bl, input logic [7:0] ba, input logic [7:0] bd,
      input logic eag, input logic ebg,
      input logic earv, input logic [7:0] eard, input logic ebrv, input logic [7:0] ebrd);
      vec_t v;
      v.rst = r;
      v.ar = ar; v.aw = aw; v.al = al; v.aa = aa; v.ad = ad;
      v.br = br; v.bw = bw; v.bl = bl; v.ba = ba; v.bd = bd;
      v.eag = eag; v.ebg = ebg;
      v.earv = earv; v.eard = eard; v.ebrv = ebrv; v.ebrd = ebrd;
      return v;
   endfunction

   vec_t vecs [$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   initial begin
      logic       exp_cs, exp_we;
      logic [7:0] exp_addr, exp_wdata;

      //            rst ar aw al aa     ad     br bw bl ba     bd     ag bg arv ard    brv brd
      // Reset with both requesting writes
      vecs.push_back(mk(1, 1,1,0, 8'h20, 8'hFF, 1,1,0, 8'h21, 8'hEE, 0,0, 0,8'h00, 0,8'h00));
      vecs.push_back(mk(1, 1,1,0, 8'h20, 8'hFF, 1,1,0, 8'h21, 8'hEE, 0,0, 0,8'h00, 0,8'h00));
      // A alone: write then read back
      vecs.push_back(mk(0, 1,1,0, 8'h10, 8'h5A, 0,0,0, 8'h00, 8'h00, 1,0, 0,8'h00, 0,8'h00));
      vecs.push_back(mk(0, 1,0,0, 8'h10, 8'h00, 0,0,0, 8'h00, 8'h00, 1,0, 0,8'h00, 0,8'h00));
      vecs.push_back(mk(0, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0,0, 1,8'h5A, 0,8'h00));
      vecs.push_back(mk(0, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0,0, 0,8'h5A, 0,8'h00));
      // Reset, then plain round-robin reads
      vecs.push_back(mk(1, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0,0, 0,8'h5A, 0,8'h00));
      vecs.push_back(mk(0, 1,0,0, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 0,8'h00, 0,8'h00));
      vecs.push_back(mk(0, 1,0,0, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 0,1, 1,8'h5A, 0,8'h00));
      vecs.push_back(mk(0, 1,0,0, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 0,8'h5A, 1,8'hD2));
      vecs.push_back(mk(0, 1,0,0, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 0,1, 1,8'h5A, 0,8'hD2));
      // Locked A bursts of 4 with B contending
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 0,8'h5A, 1,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 0,1, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 0,8'h5A, 1,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 0,1, 1,8'h5A, 0,8'hD2));
      // Locked A drops req in its 3rd cycle: B granted in that same cycle
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 0,8'h5A, 1,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 0,0,0, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 0,1, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 0,0,0, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 0,1, 0,8'h5A, 1,8'hD2));
      // Reset in the middle of a locked A read burst
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 0,0,0, 8'h11, 8'h00, 1,0, 0,8'h5A, 1,8'hD2));
      vecs.push_back(mk(0, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(1, 1,0,1, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 0,0, 1,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 1,0,0, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 1,0, 0,8'h00, 0,8'h00));
      vecs.push_back(mk(0, 1,0,0, 8'h10, 8'h00, 1,0,0, 8'h11, 8'h00, 0,1, 1,8'h5A, 0,8'h00));
      // B write then read back; the write raises no rvalid
      vecs.push_back(mk(0, 0,0,0, 8'h00, 8'h00, 1,1,0, 8'h30, 8'h77, 0,1, 0,8'h5A, 1,8'hD2));
      vecs.push_back(mk(0, 0,0,0, 8'h00, 8'h00, 1,0,0, 8'h30, 8'h00, 0,1, 0,8'h5A, 0,8'hD2));
      vecs.push_back(mk(0, 0,0,0, 8'h00, 8'h00, 0,0,0, 8'h00, 8'h00, 0,0, 0,8'h5A, 1,8'h77));

      for (int i = 0; i < vecs.size(); i++) begin
         rst    = vecs[i].rst;
         a_req  = vecs[i].ar; a_we = vecs[i].aw; a_lock = vecs[i].al;
         a_addr = vecs[i].aa; a_wdata = vecs[i].ad;
         b_req  = vecs[i].br; b_we = vecs[i].bw; b_lock = vecs[i].bl;
         b_addr = vecs[i].ba; b_wdata = vecs[i].bd;
         exp_cs    = vecs[i].eag | vecs[i].ebg;
         exp_we    = (vecs[i].eag & vecs[i].aw) | (vecs[i].ebg & vecs[i].bw);
         exp_addr  = vecs[i].ebg ? vecs[i].ba : vecs[i].aa;
         exp_wdata = vecs[i].ebg ? vecs[i].bd : vecs[i].ad;
         @(negedge clk);
         total_cnt++;
         if (a_gnt === vecs[i].eag && b_gnt === vecs[i].ebg && ram_cs === exp_cs &&
             ram_we === exp_we && (!exp_cs || ram_addr === exp_addr) &&
             (!exp_we || ram_wdata === exp_wdata) &&
             a_rvalid === vecs[i].earv && a_rdata === vecs[i].eard &&
             b_rvalid === vecs[i].ebrv && b_rdata === vecs[i].ebrd) begin
            pass_cnt++;
            $display("vec%0d ok: gnt=%b%b cs=%b we=%b addr=%h arv=%b ard=%h brv=%b brd=%h",
                     i, a_gnt, b_gnt, ram_cs, ram_we, ram_addr, a_rvalid, a_rdata, b_rvalid, b_rdata);
         end else begin
            $display("FAIL vec%0d: got gnt=%b%b cs=%b we=%b addr=%h wd=%h arv=%b ard=%h brv=%b brd=%h; want gnt=%b%b cs=%b we=%b addr=%h wd=%h arv=%b ard=%h brv=%b brd=%h",
                     i, a_gnt, b_gnt, ram_cs, ram_we, ram_addr, ram_wdata, a_rvalid, a_rdata, b_rvalid, b_rdata,
                     vecs[i].eag, vecs[i].ebg, exp_cs, exp_we, exp_addr, exp_wdata,
                     vecs[i].earv, vecs[i].eard, vecs[i].ebrv, vecs[i].ebrd);
         end
         @(posedge clk);
         #1;
      end

      // RAM contents: reset-cycle writes dropped, granted writes committed
      total_cnt++;
      if (mem[8'h20] === 8'hE3 && mem[8'h21] === 8'hE2) begin
         pass_cnt++;
         $display("mem_reset ok: mem[20]=%h mem[21]=%h", mem[8'h20], mem[8'h21]);
      end else begin
         $display("FAIL mem_reset: got mem[20]=%h mem[21]=%h, want e3 e2", mem[8'h20], mem[8'h21]);
      end
      total_cnt++;
      if (mem[8'h10] === 8'h5A && mem[8'h30] === 8'h77) begin
         pass_cnt++;
         $display("mem_write ok: mem[10]=%h mem[30]=%h", mem[8'h10], mem[8'h30]);
      end else begin
         $display("FAIL mem_write: got mem[10]=%h mem[30]=%h, want 5a 77", mem[8'h10], mem[8'h30]);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 256x8 data RAM.
- Requester A is the CPU datapath. Requester B is the program loader/debug port.
- Issues one RAM access per clock to the granted requester. Round-robin fairness, optional locked bursts with a bounded hold.
- Registers read data back to the requester that issued the read.

Parameters:
- AW, 8, address width (RAM depth 2^AW)
- DW, 8, data width
- MAX_BURST, 4, max consecutive grants to one requester while locked (>=1)

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- a_req  in  1  A requests an access this cycle
- a_we  in  1  A access is a write (1) or read (0)
- a_lock  in  1  A asks to keep ownership after this grant
- a_addr  in  AW  A address
- a_wdata  in  DW  A write data
- a_gnt  out  1  A access performed this cycle (combinational)
- a_rdata  out  DW  A registered read data
- a_rvalid  out  1  one-cycle pulse: a_rdata holds a new read result
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid: same as A, for requester B
- ram_cs  out  1  RAM access active
- ram_we  out  1  RAM write enable (RAM commits on negedge of same cycle)
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM combinational read data

Behaviour:
- State: owner FSM {IDLE, OWN_A, OWN_B}; last (1 bit, last granted requester); hold_cnt (counts 0..MAX_BURST).
- Reset values: state=IDLE, last=B (so A wins the first tie), hold_cnt=0, a_rdata=b_rdata=0, a_rvalid=b_rvalid=0.
- During rst: a_gnt, b_gnt, ram_cs and ram_we are forced 0.
- Grant selection (combinational, at most one grant per cycle):
  - IDLE:
    - Only one requester has req set: grant it.
    - Both request: grant the one that is not `last`.
    - Neither requests: no grant.
  - OWN_X, x_req=1: grant X. The other requester is denied even if it is requesting.
  - OWN_X, x_req=0: ownership lapses this cycle. Arbitrate as IDLE (last=X), so the other requester is granted in the same cycle if requesting.
- RAM drive:
  - ram_cs = a_gnt|b_gnt.
  - ram_we = (a_gnt&a_we)|(b_gnt&b_we).
  - ram_addr and ram_wdata come from the granted requester. With no grant they come from A; don't-care because ram_we=0.
- Update on a granted cycle for requester X (posedge):
  - last <= X.
  - If the previous state was not OWN_X: hold_cnt <= 1. Otherwise hold_cnt <= hold_cnt+1.
  - If x_lock=1 and the new hold_cnt < MAX_BURST: state <= OWN_X. Otherwise state <= IDLE and hold_cnt <= 0.
- Forced release: after MAX_BURST consecutive grants the state returns to IDLE with last=X.
  - The other requester wins if it is requesting.
  - If not, X is re-granted and a new burst count starts at 1.
- No-grant cycle: state <= IDLE, hold_cnt <= 0, last unchanged.
- MAX_BURST=1: locking has no effect; pure round-robin.
- Read return:
  - A granted read by X (x_we=0) captures ram_rdata into x_rdata at the posedge ending the grant cycle. x_rvalid=1 for exactly the following cycle.
  - Back-to-back reads give back-to-back rvalid pulses.
  - x_rdata holds its value until the next read by X.
  - Writes never raise rvalid.
- Latency: grant 0 cycles (same cycle as req when uncontended); read data 1 cycle after grant; write visible to a read in the next cycle.
- Requester rule: a requester keeps req/we/addr/wdata stable until it sees gnt. The arbiter does not queue requests.
- Reset mid-operation: all state returns to reset values and pending read returns are dropped (rvalid=0 next cycle). A write presented in a reset cycle is not performed.

Test Plan:
- Reset: rst=1 for 2 cycles with a_req=b_req=1, a_we=1 -> a_gnt=b_gnt=0, ram_we=0, rvalid=0; RAM[a_addr] unchanged.
- A alone: write 0x10<-0x5A, then read 0x10 -> a_gnt=1 both cycles; a_rvalid=1 in the cycle after the read with a_rdata=0x5A; b_rvalid stays 0.
- Both request continuously, no lock, right after reset -> grants A,B,A,B,...; every cycle has exactly one grant and ram_cs=1.
- a_lock=1, MAX_BURST=4, both requesting -> A granted 4 consecutive cycles, B 1 cycle, then A 4 cycles; b_gnt never asserted inside an A burst.
- a_lock=1, A drops a_req in its 3rd cycle while b_req=1 -> b_gnt=1 in that same cycle; state IDLE afterwards.
- rst asserted during an A locked read burst -> a_rvalid=0 in the following cycle; after rst deasserts with both requesting, A is granted first.
